// File: rtl/arb_requester.sv
// arb_requester: FIFO-buffered arbiter requester that streams bounded bursts onto a shared bus
module arb_requester #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int BURST_LEN = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    input  logic [DATA_W-1:0]          in_data_i,
    output logic                       in_ready_o,
    output logic                       req_o,
    input  logic                       gnt_i,
    output logic                       out_valid_o,
    output logic [DATA_W-1:0]          out_data_o,
    output logic                       out_last_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              push, pop, empty;

    // Handshake decode: ready/count from registered state only, bus outputs follow gnt_i combinationally
    always_comb begin
        empty       = count_q == '0;
        in_ready_o  = count_q < CW'(DEPTH);
        push        = in_valid_i & in_ready_o;
        req_o       = state_q != IDLE;
        out_valid_o = (state_q == XFER) & gnt_i & ~empty;
        out_last_o  = out_valid_o & ((beat_q == BW'(BURST_LEN - 1)) | (count_q == CW'(1)));
        out_data_o  = mem_q[rd_ptr_q];
        pop         = out_valid_o;
        count_o     = count_q;
    end

    // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Next state: last word forces a one-cycle IDLE gap; losing the grant falls back to REQ
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: state_d = empty ? IDLE : REQ;
            REQ: begin
                state_d = gnt_i ? XFER : REQ;
                beat_d  = gnt_i ? '0 : beat_q;
            end
            XFER: begin
                state_d = !gnt_i ? REQ : ((out_last_o || empty) ? IDLE : XFER);
                beat_d  = (gnt_i && !out_last_o && !empty) ? beat_q + 1'b1 : beat_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset flushes the FIFO and abandons any burst in progress
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            beat_q   <= beat_d;
        end
    end

    // Word storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: randomized and directed scoreboard bench for arb_requester
module tb_arb_requester;
    localparam int DEPTH = 4;
    localparam int BL    = 2;

    logic       clk_i = 0, rst_i = 0, in_valid_i = 0, gnt_i = 0;
    logic [7:0] in_data_i = 0;
    logic       in_ready_o, req_o, out_valid_o, out_last_o;
    logic [7:0] out_data_o;
    logic [2:0] count_o;

    arb_requester #(.DATA_W(8), .DEPTH(DEPTH), .BURST_LEN(BL)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
        .in_ready_o(in_ready_o), .req_o(req_o), .gnt_i(gnt_i), .out_valid_o(out_valid_o),
        .out_data_o(out_data_o), .out_last_o(out_last_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {logic [7:0] d; logic l;} beat_t;

    int total = 0, bad = 0;
    logic [7:0] mq[$];
    beat_t exp_q[$];
    bit m_req, m_own, chk_en;
    int m_sent;
    bit p_v, p_g, p_x, p_last;
    logic [7:0] p_d;
    bit e_req, e_rdy, e_val;
    int e_cnt;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the bus owes this cycle given queued words and ownership
    task automatic predict();
        e_req = m_req;
        e_cnt = mq.size();
        e_rdy = mq.size() < DEPTH;
        p_x = m_own && gnt_i && mq.size() > 0;
        e_val = p_x;
        p_last = 0;
        if (p_x) begin
            p_last = (m_sent == BL - 1) || (mq.size() == 1);
            exp_q.push_back({mq[0], p_last});
        end
        p_v = in_valid_i;
        p_d = in_data_i;
        p_g = gnt_i;
    endtask

    // Reference: consequences of the clock edge that closes the current cycle
    task automatic advance();
        int n;
        n = mq.size();
        if (p_x) void'(mq.pop_front());
        if (p_v && n < DEPTH) mq.push_back(p_d);
        if (!m_req) m_req = n > 0;
        else if (!m_own) begin
            if (p_g) begin
                m_own = 1;
                m_sent = 0;
            end
        end else if (!p_g) m_own = 0;
        else if (p_x && !p_last) m_sent++;
        else begin
            m_req = 0;
            m_own = 0;
        end
    endtask

    task automatic cycle(input bit v, input logic [7:0] d, input bit g);
        @(posedge clk_i);
        advance();
        #1;
        in_valid_i = v;
        in_data_i = d;
        gnt_i = g;
        predict();
    endtask

    task automatic release_reset();
        @(posedge clk_i);
        #1;
        rst_i = 0;
        mq.delete();
        exp_q.delete();
        m_req = 0;
        m_own = 0;
        m_sent = 0;
        in_valid_i = 0;
        gnt_i = 0;
        predict();
        chk_en = 1;
    endtask

    // Monitor: compare handshake state every cycle and pop the scoreboard on each expected beat
    always @(negedge clk_i) begin
        beat_t b;
        if (chk_en) begin
            check("req", int'(req_o), int'(e_req));
            check("count", int'(count_o), e_cnt);
            check("ready", int'(in_ready_o), int'(e_rdy));
            check("valid", int'(out_valid_o), int'(e_val));
            if (e_val && exp_q.size() > 0) begin
                b = exp_q.pop_front();
                if (out_valid_o) begin
                    check("data", int'(out_data_o), int'(b.d));
                    check("last", int'(out_last_o), int'(b.l));
                end
            end
        end
    end

    initial begin
        int n;
        #1 rst_i = 1;
        #1;
        check("rst_req", int'(req_o), 0);
        check("rst_valid", int'(out_valid_o), 0);
        check("rst_last", int'(out_last_o), 0);
        check("rst_count", int'(count_o), 0);
        check("rst_ready", int'(in_ready_o), 1);
        release_reset();
        cycle(1, 8'hA5, 1);
        repeat (5) cycle(0, 8'h00, 1);
        for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 1);
        repeat (10) cycle(0, 8'h00, 1);
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'h10 + i), 0);
        n = 0;
        while (!p_x && n < 20) begin
            cycle(0, 8'h00, 1);
            n++;
        end
        check("preempt_first_beat", int'(n < 20), 1);
        repeat (2) cycle(0, 8'h00, 0);
        repeat (8) cycle(0, 8'h00, 1);
        for (int i = 0; i < 4; i++) cycle(1, 8'(8'h20 + i), 0);
        cycle(1, 8'hEE, 0);
        repeat (2) cycle(0, 8'h00, 0);
        repeat (12) cycle(0, 8'h00, 1);
        for (int i = 0; i < 6; i++) cycle(1, 8'(8'h30 + i), 1);
        repeat (12) cycle(0, 8'h00, 1);
        repeat (400) cycle(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0);
        repeat (12) cycle(0, 8'h00, 1);
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'h40 + i), 0);
        n = 0;
        while (!m_req && n < 10) begin
            cycle(0, 8'h00, 0);
            n++;
        end
        cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 1);
        check("pre_rst_count", int'(count_o), 3);
        #2;
        chk_en = 0;
        rst_i = 1;
        #1;
        check("mid_rst_req", int'(req_o), 0);
        check("mid_rst_valid", int'(out_valid_o), 0);
        check("mid_rst_last", int'(out_last_o), 0);
        check("mid_rst_count", int'(count_o), 0);
        check("mid_rst_ready", int'(in_ready_o), 1);
        release_reset();
        repeat (6) cycle(0, 8'h00, 1);
        @(posedge clk_i);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/arb_requester.md
# arb_requester

Requester-side front end for the team's fixed-priority arbiter: one instance sits on each arbiter port and buffers client words in a small FIFO. It drives the port's request line while work is pending and consumes the grant line. While granted, it streams a bounded burst of words onto the shared bus, then releases the request for one cycle. This keeps ownership bounded and lets lower-priority ports be served.

## Interface
- DATA_W, default 8: width of each buffered word.
- DEPTH, default 4: FIFO entries; must be a power of two, ≥2.
- BURST_LEN, default 2: maximum words sent per grant; ≥1, ≤DEPTH.

- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- in_valid_i  input  1  client offers in_data_i this cycle.
- in_data_i  input  DATA_W  client word.
- in_ready_o  output  1  FIFO can accept a word; equals count_o < DEPTH.
- req_o  output  1  request to the arbiter port; registered, driven from FSM state only.
- gnt_i  input  1  grant from the arbiter port; may change combinationally with any requester's req.
- out_valid_o  output  1  a word is on the shared bus this cycle.
- out_data_o  output  DATA_W  FIFO head; valid only when out_valid_o = 1.
- out_last_o  output  1  final word of the current burst; valid only with out_valid_o.
- count_o  output  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- FIFO:
  - Push when in_valid_i & in_ready_o. Pop when out_valid_o.
  - Push and pop in the same cycle leave count_o unchanged.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - When full, in_ready_o = 0 even if a pop occurs in the same cycle. No push bypass.
- FSM states:
  - IDLE: req_o = 0. Goes to REQ next edge if count_o > 0.
  - REQ: req_o = 1. On an edge with gnt_i = 1, goes to XFER and clears beat counter.
  - XFER: req_o = 1.
    - out_valid_o = gnt_i & (count_o > 0). Each transferring cycle pops one word and increments the beat counter.
    - out_last_o = out_valid_o & (beat == BURST_LEN-1 or count_o == 1).
    - After a last word, go to IDLE. The forced one-cycle req_o gap is mandatory even if words remain.
    - If gnt_i = 0 in XFER (preempted by a higher priority), transfer nothing that cycle and return to REQ. The beat counter restarts at 0 on the next grant.
- Beat counter width: $clog2(BURST_LEN+1) bits. It never exceeds BURST_LEN-1.
- out_valid_o is never asserted outside XFER or when the FIFO is empty.
- Reset (asynchronous, any time, including mid-burst):
  - Effects are immediate: state = IDLE, FIFO flushed, beat = 0.
  - Outputs: req_o = 0, out_valid_o = 0, out_last_o = 0, count_o = 0, in_ready_o = 1.
  - No partial burst resumes after reset release.

## Timing
- Push in cycle 0 into an empty FIFO:
  - count_o = 1 in cycle 1, state IDLE.
  - req_o = 1 in cycle 2.
  - If gnt_i = 1 in cycle 2, the first out_valid_o is in cycle 3.
- Best-case latency from push to bus is 3 cycles.
- Steady grant: one word per cycle for up to BURST_LEN cycles, then req_o = 0 for exactly 1 cycle, then 1 cycle in REQ before the next burst.
- in_ready_o and count_o depend only on registered state; they have no combinational path from gnt_i.
- out_valid_o, out_data_o and out_last_o have a combinational path from gnt_i (same-cycle transfer).

## Test plan
- Reset values: assert rst_i mid-cycle with the FIFO holding 3 words in XFER.
  - Required: req_o, out_valid_o, count_o all 0 immediately; in_ready_o = 1; state IDLE after release.
- Single word: push 0xA5 in cycle 0, gnt_i tied 1.
  - Required: req_o high cycle 2; out_valid_o = 1, out_data_o = 0xA5, out_last_o = 1 in cycle 3; req_o = 0 in cycle 4.
- Burst split, BURST_LEN = 2: push 0x01–0x04, gnt_i = 1.
  - Required: 0x01, 0x02 (last); one req_o-low cycle; REQ cycle; then 0x03, 0x04 (last).
- Preemption: 3 words queued; gnt_i drops for 2 cycles after the first beat.
  - Required: no out_valid_o while gnt_i = 0; FSM in REQ; next grant sends a 2-word burst with out_last_o on the second word.
- Full/wrap, DEPTH = 4:
  - Push 4 words with gnt_i = 0. Required: count_o = 4, in_ready_o = 0, a 5th offer is not accepted.
  - Then drain and push 6 more. Required: data order is preserved across pointer wrap.
